// File: rtl/action_mmio_pkg.sv
// Shared definitions for the action MMIO initiator: register window offsets, FSM and step encodings.
package action_mmio_pkg;

  localparam int ACTION_W_DEF = 64;

  localparam logic [7:0] OFF_ACTION_LO  = 8'h00;
  localparam logic [7:0] OFF_ACTION_HI  = 8'h04;
  localparam logic [7:0] OFF_VALID      = 8'h08;
  localparam logic [7:0] OFF_PKT_START  = 8'h0C;
  localparam logic [7:0] OFF_DRAIN      = 8'h10;
  localparam logic [7:0] OFF_LATCHED_LO = 8'h14;
  localparam logic [7:0] OFF_LATCHED_HI = 8'h18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_GAP,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    STEP_WR_LO,
    STEP_WR_HI,
    STEP_WR_VALID,
    STEP_WR_START,
    STEP_POLL,
    STEP_RD_LO,
    STEP_RD_HI
  } step_t;

  function automatic logic [7:0] step_offset(input step_t s);
    case (s)
      STEP_WR_LO:    return OFF_ACTION_LO;
      STEP_WR_HI:    return OFF_ACTION_HI;
      STEP_WR_VALID: return OFF_VALID;
      STEP_WR_START: return OFF_PKT_START;
      STEP_POLL:     return OFF_DRAIN;
      STEP_RD_LO:    return OFF_LATCHED_LO;
      STEP_RD_HI:    return OFF_LATCHED_HI;
      default:       return OFF_ACTION_LO;
    endcase
  endfunction

  function automatic logic step_is_write(input step_t s);
    return (s == STEP_WR_LO) || (s == STEP_WR_HI) ||
           (s == STEP_WR_VALID) || (s == STEP_WR_START);
  endfunction

  // Pulse registers only look at bit 0; reads drive zero write data.
  function automatic logic [31:0] step_wdata(input step_t s, input logic [63:0] act);
    case (s)
      STEP_WR_LO:    return act[31:0];
      STEP_WR_HI:    return act[63:32];
      STEP_WR_VALID: return 32'h0000_0001;
      STEP_WR_START: return 32'h0000_0001;
      default:       return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/action_poll_timer.sv
// Saturating allow-drain poll counter; 'last' flags that one more failed poll reaches LIMIT.
module action_poll_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] poll_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (clear) begin
      poll_cnt <= '0;
    end else if (inc && (poll_cnt != CW'(LIMIT))) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign last = (poll_cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/action_mmio_initiator.sv
// Hardware bus master that replays the firmware action-programming sequence on the native mem bus.
// Define ACTION_MMIO_INIT_TIMEOUT_EN to bound allow-drain polling to POLL_LIMIT attempts.
module action_mmio_initiator
  import action_mmio_pkg::*;
#(
  parameter int          ACTION_W   = ACTION_W_DEF,
  parameter logic [31:0] BASE_ADDR  = 32'h0301_0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ACTION_W-1:0] cmd_action,
  input  logic                cmd_pkt_start,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic [31:0]         mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ACTION_W-1:0] rsp_action,
  output logic                rsp_timeout,
  output logic                busy
);

  state_t              state;
  step_t               step;
  step_t               step_nxt;
  step_t               ld_step;
  logic [ACTION_W-1:0] act_q;
  logic [ACTION_W-1:0] ld_act;
  logic                pkt_q;
  logic                accept;
  logic                bus_done;
  logic                poll_fail;
  logic                poll_last;
  logic                seq_end;
  logic                timed_out;

  if (POLL_LIMIT < 1) begin : g_bad_poll_limit
    $error("POLL_LIMIT must be at least 1");
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign bus_done  = (state == ST_BUS) && mem_ready;

  // Bus fields are loaded either on accept (first step, straight from the command) or from GAP.
  assign ld_step = (state == ST_IDLE) ? STEP_WR_LO : step;
  assign ld_act  = (state == ST_IDLE) ? cmd_action : act_q;

`ifdef ACTION_MMIO_INIT_TIMEOUT_EN
  action_poll_timer #(
    .LIMIT(POLL_LIMIT)
  ) u_poll_timer (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .inc  (bus_done && poll_fail),
    .last (poll_last)
  );
`else
  assign poll_last = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no latch is inferred on any path.
  always_comb begin
    step_nxt  = step;
    poll_fail = 1'b0;
    seq_end   = 1'b0;
    timed_out = 1'b0;
    unique case (step)
      STEP_WR_LO:    step_nxt = STEP_WR_HI;
      STEP_WR_HI:    step_nxt = STEP_WR_VALID;
      STEP_WR_VALID: step_nxt = pkt_q ? STEP_WR_START : STEP_POLL;
      STEP_WR_START: step_nxt = STEP_POLL;
      STEP_POLL: begin
        if (mem_rdata[0]) begin
          step_nxt = STEP_RD_LO;
        end else begin
          poll_fail = 1'b1;
          seq_end   = poll_last;
          timed_out = poll_last;
        end
      end
      STEP_RD_LO:    step_nxt = STEP_RD_HI;
      STEP_RD_HI:    seq_end  = 1'b1;
      default:       step_nxt = STEP_WR_LO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      step        <= STEP_WR_LO;
      act_q       <= '0;
      pkt_q       <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      rsp_valid   <= 1'b0;
      rsp_action  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            act_q       <= cmd_action;
            pkt_q       <= cmd_pkt_start;
            step        <= STEP_WR_LO;
            rsp_action  <= '0;
            rsp_timeout <= 1'b0;
            state       <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (step == STEP_RD_LO) rsp_action[31:0]  <= mem_rdata;
            if (step == STEP_RD_HI) rsp_action[63:32] <= mem_rdata;
            if (seq_end) begin
              rsp_valid   <= 1'b1;
              rsp_timeout <= timed_out;
              state       <= ST_RESP;
            end else begin
              step  <= step_nxt;
              state <= ST_GAP;
            end
          end
        end
        ST_GAP:  state <= ST_BUS;
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (accept || (state == ST_GAP)) begin
        mem_valid <= 1'b1;
        mem_addr  <= BASE_ADDR + {24'h0, step_offset(ld_step)};
        mem_wdata <= step_wdata(ld_step, ld_act);
        mem_wstrb <= step_is_write(ld_step) ? 4'hF : 4'h0;
      end
    end
  end

endmodule

// File: doc/action_mmio_initiator.md
# action_mmio_initiator

Bus-master counterpart to the action MMIO register block: it accepts a 64-bit action plus packet-start flag from hardware and drives the native `mem_valid/mem_ready` memory bus through the same programming sequence that firmware uses on the action window at BASE_ADDR. The sequence is: write the action low and high words, pulse action-valid, optionally pulse pkt-start, poll allow-drain, then read back the latched action. It sits beside the CPU on the SoC bus arbiter and lets the packet pipeline program the action path without firmware involvement.

## Interface

- `ACTION_W`, 64: action width; fixed at 64 (two 32-bit words).
- `BASE_ADDR`, 32'h0301_0000: base of the target action register window.
- `POLL_LIMIT`, 1024: maximum allow-drain polls before timeout; must be ≥1.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_action` in 64: action to program.
- `cmd_pkt_start` in 1: also issue the pkt-start write.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus completion; may be combinational from `mem_valid`.
- `mem_addr` out 32: BASE_ADDR + offset.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: 4'hF for writes, 4'h0 for reads.
- `mem_rdata` in 32: read data, valid in the cycle where `mem_ready` is high.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: result consumed.
- `rsp_action` out 64: latched action read back from the target.
- `rsp_timeout` out 1: poll limit reached.
- `busy` out 1: state is not IDLE.

## Operation

- FSM states:
  - IDLE: `cmd_ready`=1. On accept, register `cmd_action` and `cmd_pkt_start`, set step=WR_LO, go to BUS.
  - BUS: `mem_valid`=1. Hold `mem_addr`, `mem_wdata` and `mem_wstrb` stable until `mem_ready`=1. On `mem_ready`, go to GAP, or to RESP after the final step.
  - GAP: one cycle with `mem_valid`=0, then return to BUS with the next step.
  - RESP: `rsp_valid`=1. Hold all outputs until `rsp_ready`=1, then go to IDLE.
- Step order and target offsets:
  - WR_LO (0x00, `action[31:0]`)
  - WR_HI (0x04, `action[63:32]`)
  - WR_VALID (0x08, data 1)
  - WR_START (0x0C, data 1), executed only if the registered pkt_start is 1; otherwise skipped
  - POLL (0x10, read)
  - RD_LO (0x14, read)
  - RD_HI (0x18, read)
- POLL completion:
  - If `mem_rdata[0]`=1, next step is RD_LO.
  - Otherwise increment `poll_cnt` and repeat POLL after GAP.
- RD_LO and RD_HI capture `mem_rdata` into `rsp_action[31:0]` and `rsp_action[63:32]` in their `mem_ready` cycle.
- Timeout: a failed poll that brings `poll_cnt` to POLL_LIMIT ends the sequence. The block goes to RESP with `rsp_timeout`=1, `rsp_action`=0 and no read-back.
- `poll_cnt` clears on command accept and saturates; it never wraps.
- `cmd_valid` asserted while busy is ignored (no accept); the command is taken once the block returns to IDLE.
- Write data drives only bit 0 for WR_VALID and WR_START; the upper bits are 0.

## Timing

- Reset values:
  - `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0.
  - `rsp_valid`=0, `rsp_action`=0, `rsp_timeout`=0.
  - `busy`=0, `cmd_ready`=1, `poll_cnt`=0, state IDLE.
- Reset asserted mid-transaction drops `mem_valid` asynchronously and abandons the sequence; no response is produced.
- All bus outputs are registered. `mem_valid` rises the cycle after accept.
- Zero-wait target (`mem_ready` combinational) gives a 2-cycle transaction (BUS + GAP).
- Latency from accept to `rsp_valid`, zero-wait bus, first poll successful:
  - pkt_start=1: 14 cycles.
  - pkt_start=0: 12 cycles.
  - Each failed poll adds 2 cycles; each bus wait cycle adds 1.
- `rsp_valid` stays asserted and stable for one or more cycles until `rsp_ready`. `cmd_ready` rises the cycle after the response handshake.

## Configuration

- `ACTION_MMIO_INIT_TIMEOUT_EN`:
  - Defined: POLL_LIMIT timeout as described above.
  - Undefined: the poll counter is removed, POLL repeats indefinitely, and `rsp_timeout` is tied to 0.

## Structure

- Shared package `action_mmio_pkg`:
  - Register offset constants 0x00–0x18.
  - FSM state enum (IDLE/BUS/GAP/RESP).
  - Step enum (WR_LO…RD_HI).
  - The `ACTION_W` default.
- Optional sub-module `action_poll_timer` (count, saturate, limit flag), instantiated only under `ACTION_MMIO_INIT_TIMEOUT_EN`. All other logic stays in one module.

## Test plan

- Zero-wait target, action 64'hDEAD_BEEF_0123_4567, pkt_start=1, allow-drain returns 1 on first poll:
  - Writes 0x03010000=0x01234567, 0x03010004=0xDEADBEEF, 0x03010008=1, 0x0301000C=1.
  - Reads 0x10, 0x14, 0x18.
  - `rsp_valid` 14 cycles after accept, `rsp_action` = the read-back words.
- Same command with pkt_start=0: no access to 0x0C; `rsp_valid` at 12 cycles.
- Target holds `mem_ready` low for 3 cycles on WR_HI: addr, wdata and wstrb are stable across all 4 BUS cycles; total latency increases by 3.
- allow-drain reads 0 five times, then 1: exactly 6 reads of 0x10, then read-back; latency increases by 10.
- Timeout enabled, POLL_LIMIT=4, allow-drain always 0: 4 polls, then `rsp_timeout`=1 and `rsp_action`=0. With the macro undefined, polling continues past 100 polls with no response.
- `reset` pulsed during the WR_VALID BUS cycle: `mem_valid`=0 immediately and state IDLE. A new command afterwards runs the full sequence from WR_LO. `rsp_ready` held low for 5 cycles keeps `rsp_valid` and `rsp_action` stable.
